// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads system ID word 0 and timestamp word 1 after reset/start and flags mismatch or timeout
//   clock, reset          : system clock, asynchronous active-high reset
//   start                 : one-cycle pulse, starts a new check when resting in DONE
//   avm_address/avm_read  : read master to the ID slave (0 = ID, 1 = timestamp)
//   avm_readdata/avm_waitrequest/avm_readdatavalid : slave response
//   busy, done            : check in progress / finished (done held until next check)
//   id_ok, ts_ok, timeout : comparison and timeout status, valid with done
//   id_value, ts_value    : captured words
//   SYSID_CHECK_PERIODIC_EN: when defined, re-runs the check every PERIOD_CYCLES spent in DONE
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h6045_2F0D,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned PERIOD_CYCLES  = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  localparam logic [2:0] BOOT       = 3'd0;
  localparam logic [2:0] RD_ID_REQ  = 3'd1;
  localparam logic [2:0] RD_ID_WAIT = 3'd2;
  localparam logic [2:0] RD_TS_REQ  = 3'd3;
  localparam logic [2:0] RD_TS_WAIT = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [2:0] state;
  logic [15:0] cnt;
  logic req, rd_wait, ts_phase, hit, got, finish_ok, tmo, kick;
  assign req       = state == RD_ID_REQ || state == RD_TS_REQ;
  assign rd_wait   = state == RD_ID_WAIT || state == RD_TS_WAIT;
  assign ts_phase  = state == RD_TS_REQ || state == RD_TS_WAIT;
  assign hit       = cnt == CNT_LAST;
  // data arriving on the limit cycle still counts as a successful read
  assign got       = rd_wait && avm_readdatavalid;
  assign finish_ok = got && ts_phase;
  assign tmo       = (req || rd_wait) && hit && !got;
  // the request is withdrawn on the limit cycle so no command can be accepted as we abort
  assign avm_read    = req && !hit;
  assign avm_address = ts_phase;
`ifdef SYSID_CHECK_PERIODIC_EN
  logic [31:0] per_cnt;
  assign kick = start || per_cnt == 32'(PERIOD_CYCLES - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) per_cnt <= '0;
    else per_cnt <= state == DONE && !kick ? per_cnt + 32'd1 : '0;
`else
  logic unused_period;
  assign unused_period = PERIOD_CYCLES != 0;
  assign kick = start;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (req || rd_wait) cnt <= cnt + 16'd1;
      case (state)
        BOOT: begin
          state <= RD_ID_REQ;
          busy  <= 1'b1;
        end
        RD_ID_REQ: if (!avm_waitrequest && !hit) state <= RD_ID_WAIT;
        RD_TS_REQ: if (!avm_waitrequest && !hit) state <= RD_TS_WAIT;
        RD_ID_WAIT: if (got) begin
          id_value <= avm_readdata;
          state    <= RD_TS_REQ;
          cnt      <= '0;
        end
        RD_TS_WAIT: if (got) ts_value <= avm_readdata;
        DONE: if (kick) begin
          state    <= RD_ID_REQ;
          cnt      <= '0;
          busy     <= 1'b1;
          done     <= 1'b0;
          id_ok    <= 1'b0;
          ts_ok    <= 1'b0;
          timeout  <= 1'b0;
          id_value <= '0;
          ts_value <= '0;
        end
        default: state <= BOOT;
      endcase
      // an ID is only judged once it has been captured, i.e. we reached the timestamp phase
      if (finish_ok || tmo) begin
        state   <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= tmo;
        id_ok   <= ts_phase && id_value == EXPECTED_ID;
        ts_ok   <= finish_ok && avm_readdata == EXPECTED_TS;
      end
    end
  end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: randomized slave timing/data checked against a per-read outcome model
module tb_sysid_boot_checker;
  localparam int T = 8;
  localparam int P = 20;
  localparam logic [31:0] EID = 32'h0000_0000;
  localparam logic [31:0] ETS = 32'h6045_2F0D;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  int vectors = 0;
  int errors = 0;
  logic [31:0] mem [2];
  int wt [2];
  int lt [2];
  int id_reads = 0;
  int ts_reads = 0;
  bit inject_tgl = 1'b0;
  always #5 clk = ~clk;
  sysid_boot_checker #(
    .EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(T), .PERIOD_CYCLES(P)
  ) dut (
    .clock(clk), .reset(rst), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // slave: per address, wt cycles of waitrequest then data lt cycles after acceptance
  initial begin : slave
    bit in_req, acc, acc_addr, inflight, raddr, inject_seen;
    int wcnt, lcnt;
    in_req = 0; acc = 0; acc_addr = 0; inflight = 0; raddr = 0; inject_seen = 0;
    wcnt = 0; lcnt = 0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (rst) begin
        in_req = 0; acc = 0; inflight = 0;
        avm_waitrequest = 1'b0;
      end else begin
        if (acc) begin
          inflight = 1; lcnt = lt[acc_addr]; raddr = acc_addr; acc = 0;
          if (acc_addr) ts_reads++;
          else id_reads++;
        end
        if (done) inflight = 0;
        if (inflight) begin
          lcnt--;
          if (lcnt == 0) begin
            inflight = 0;
            avm_readdatavalid = 1'b1;
            avm_readdata = mem[raddr];
          end
        end
        if (inject_tgl != inject_seen) begin
          inject_seen = inject_tgl;
          avm_readdatavalid = 1'b1;
          avm_readdata = 32'hDEAD_BEEF;
        end
        if (avm_read) begin
          if (!in_req) begin in_req = 1; wcnt = 0; end
          avm_waitrequest = wcnt < wt[avm_address];
          if (!avm_waitrequest) begin acc = 1; acc_addr = avm_address; in_req = 0; end
          wcnt++;
        end else begin
          in_req = 0;
          avm_waitrequest = 1'b0;
        end
      end
    end
  end
  // a read succeeds iff waitrequest cycles + latency fit in T-1 counts; it then costs w+l+1 cycles, else T
  task automatic launch(input string tag, input bit via_reset, input int busy_at, output int rd0);
    bit g0, g1;
    int d, n, id0, ts0;
    g0 = wt[0] + lt[0] <= T - 1;
    g1 = g0 && wt[1] + lt[1] <= T - 1;
    d = (g0 ? wt[0] + lt[0] + 1 : T) + (g0 ? (g1 ? wt[1] + lt[1] + 1 : T) : 0);
    id0 = id_reads;
    ts0 = ts_reads;
    @(negedge clk);
    if (via_reset) rst = 1'b0;
    else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    rd0 = 0;
    while (!done && n < 200) begin
      if (avm_read && !avm_address) rd0++;
      @(negedge clk);
      n++;
      start = busy_at != 0 && n == busy_at;
    end
    start = 1'b0;
    check({tag, " latency"}, n, d);
    check({tag, " done"}, done, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " timeout"}, timeout, !g1);
    check({tag, " id_ok"}, id_ok, g0 && mem[0] == EID);
    check({tag, " ts_ok"}, ts_ok, g1 && mem[1] == ETS);
    check({tag, " id_value"}, id_value, g0 ? mem[0] : 32'h0);
    check({tag, " ts_value"}, ts_value, g1 ? mem[1] : 32'h0);
    check({tag, " avm_read"}, avm_read, 0);
    check({tag, " id reads"}, id_reads - id0, wt[0] <= T - 2);
    check({tag, " ts reads"}, ts_reads - ts0, g0 && wt[1] <= T - 2);
  endtask
  initial begin
    int rd0, ts0, k;
    mem[0] = EID; mem[1] = ETS;
    wt = '{0, 0}; lt = '{1, 1};
    @(posedge clk); #1;
    check("reset status", {busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}, 0);
    check("reset id_value", id_value, 0);
    check("reset ts_value", ts_value, 0);
    // BOOT is cycle 1 after release, done appears in cycle 6 (4 cycles after RD_ID_REQ entry)
    launch("boot", 1, 0, rd0);
    mem[1] = 32'h6045_2F0E;
    launch("ts_bad", 0, 0, rd0);
    check("ts_bad literal", ts_value, 32'h6045_2F0E);
    mem[1] = ETS; wt[0] = 3;
    launch("wait3", 0, 0, rd0);
    check("wait3 id read cycles", rd0, 4);
    wt[0] = 0; lt[0] = 1000; mem[0] = 32'h1234_5678;
    launch("tmo", 0, 0, rd0);
    @(posedge clk);
    inject_tgl = ~inject_tgl;
    repeat (2) @(negedge clk);
    check("late rdv id_value", id_value, 0);
    check("late rdv done", done, 1);
    mem[0] = EID; lt[0] = 1;
    launch("busy_start", 0, 2, rd0);
    launch("restart", 0, 0, rd0);
    for (int i = 0; i < 12; i++) begin
      for (int a = 0; a < 2; a++) begin
        wt[a] = $urandom_range(0, 5);
        lt[a] = $urandom_range(0, 7) == 0 ? 1000 : $urandom_range(1, 5);
      end
      mem[0] = $urandom_range(0, 1) == 0 ? EID : $urandom;
      mem[1] = $urandom_range(0, 1) == 0 ? ETS : $urandom;
      launch($sformatf("rnd%0d", i), 0, 0, rd0);
    end
    mem[0] = 32'hA5A5_0001; mem[1] = ETS;
    wt = '{0, 0}; lt = '{1, 6};
    ts0 = ts_reads;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (ts_reads == ts0 && k < 50) begin @(negedge clk); k++; end
    check("rst reach ts_wait", ts_reads - ts0, 1);
    check("rst pre busy", busy, 1);
    check("rst pre id_value", id_value, 32'hA5A5_0001);
    #2 rst = 1'b1;
    #1;
    check("rst async status", {busy, done, id_ok, ts_ok, timeout, avm_read, avm_address}, 0);
    check("rst async id_value", id_value, 0);
    check("rst async ts_value", ts_value, 0);
    repeat (2) @(negedge clk);
    launch("after_rst", 1, 0, rd0);
`ifdef SYSID_CHECK_PERIODIC_EN
    k = 0;
    while (!avm_read && k < 100) begin @(negedge clk); k++; end
    check("period restart", k, P);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master sitting directly downstream of the system ID slave; consumes its two readdata words.
- After reset, or on a start pulse, reads word 0 (system ID) and then word 1 (build timestamp), captures both and compares them to parameterised expected values.
- Publishes pass/fail/timeout status to the boot/LED logic, so a mismatched FPGA image is flagged before software runs.

Parameters:
- EXPECTED_ID, 32'h0000_0000, value required at slave word 0.
- EXPECTED_TS, 32'h6045_2F0D, value required at slave word 1.
- TIMEOUT_CYCLES, 64, maximum cycles per read transaction, counted from assertion of avm_read until readdatavalid; legal range 2..65535.
- PERIOD_CYCLES, 50_000_000, re-check interval; used only with SYSID_CHECK_PERIODIC_EN.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse requesting a new check.
- avm_address  out  1  word address to the ID slave: 0 = ID, 1 = timestamp.
- avm_read  out  1  Avalon read request.
- avm_readdata  in  32  read data from the slave.
- avm_waitrequest  in  1  slave/interconnect stall.
- avm_readdatavalid  in  1  qualifies avm_readdata.
- busy  out  1  check in progress.
- done  out  1  check finished; holds until the next check starts.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TS.
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state = BOOT; timeout counter = 0.
- Reset asserted mid-transaction: immediate return to reset values. A readdatavalid arriving after reset release is ignored, because the FSM is not in a WAIT state.
- FSM states and transitions:
  - BOOT: one cycle after reset release -> RD_ID_REQ. busy = 1 from this cycle.
  - RD_ID_REQ: avm_read = 1, avm_address = 0; stays while avm_waitrequest = 1. When avm_waitrequest = 0 -> RD_ID_WAIT, with avm_read deasserted in the next cycle.
  - RD_ID_WAIT: avm_read = 0. When avm_readdatavalid = 1: id_value <= avm_readdata -> RD_TS_REQ. Readdatavalid in the same cycle as command acceptance is not possible; it is ignored in REQ states.
  - RD_TS_REQ / RD_TS_WAIT: identical handshake with avm_address = 1; capture into ts_value, then -> DONE.
  - DONE: busy = 0, done = 1. id_ok = (id_value == EXPECTED_ID) and ts_ok = (ts_value == EXPECTED_TS); both are registered, valid in the same cycle done rises, and held.
  - IDLE: not used; DONE is the resting state.
- Timeout:
  - A 16-bit counter clears on entry to each REQ state and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without data: avm_read forced 0, timeout = 1, -> DONE. id_ok/ts_ok are 0 for any word not captured.
  - readdatavalid in the exact cycle the count hits the limit is accepted: data wins over timeout.
- start handling:
  - start in DONE clears done, id_ok, ts_ok, timeout, id_value and ts_value, then -> RD_ID_REQ next cycle.
  - start while busy is ignored and not queued.
- Fixed-latency slave (waitrequest = 0, readdatavalid one cycle after read): BOOT to done = 6 cycles.
- Only one outstanding read at a time; avm_address is stable for the whole REQ state.

Optional Feature:
- Macro SYSID_CHECK_PERIODIC_EN.
- Defined: a 32-bit period counter runs while in DONE. When it reaches PERIOD_CYCLES-1 it behaves exactly as a start pulse, then clears. An external start also clears it. Detects a slave reconfigured or hung at run time.
- Undefined: no period counter; a check runs only after reset or on start.

Test Plan:
- Fixed-latency slave returning 0 / 32'h6045_2F0D; release reset -> done = 1 six cycles after BOOT, id_ok = 1, ts_ok = 1, timeout = 0, ts_value = 32'h6045_2F0D.
- Slave returns 32'h6045_2F0E at word 1 -> done = 1, id_ok = 1, ts_ok = 0, ts_value = 32'h6045_2F0E.
- avm_waitrequest held 3 cycles on the ID read -> avm_read and avm_address = 0 stable for 4 cycles; results as in the first scenario, done 3 cycles later.
- TIMEOUT_CYCLES = 8, readdatavalid never asserted -> 8 cycles after RD_ID_REQ entry: avm_read = 0, timeout = 1, done = 1, id_ok = 0, ts_ok = 0; a readdatavalid injected afterwards leaves id_value = 0.
- Pulse start while busy, then again after done -> first pulse ignored (single ID read seen); second clears status and repeats both reads with identical results.
- Assert reset during RD_TS_WAIT -> all outputs 0 asynchronously; after release the check restarts from word 0. With SYSID_CHECK_PERIODIC_EN and PERIOD_CYCLES = 20, a new read starts 20 cycles after done.
